b_ram_sched: RTL and testbench

Request scheduler for the partial-sum (`b`) storage RAM of the SCAN polar decoder. It has one write-request and one read-request port, both driven by the SCAN stage controller, and turns each request into a sequence of RAM beats. For each beat it drives the layer, beat counter, node address and enable inputs of the `b` RAM. Layers wider than one beat are split into multiple beats. With the hazard interlock compiled in, a read of a node that is still being written is held off until the write finishes.

---
 rtl/b_ram_sched_if.sv | 39 +++
 rtl/b_ram_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_b_ram_sched.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/b_ram_sched_if.sv
// b_ram_sched_if: request/RAM-side bundle between the SCAN stage controller,
// the b-RAM scheduler and the b RAM.
// master = controller/RAM side (drives requests, observes beats); slave = scheduler.
interface b_ram_sched_if;
  // write request port
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_layer;
  logic [8:0] wr_node;
  // read request port
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] rd_layer;
  logic [8:0] rd_node;
  // RAM-facing beat outputs
  logic [4:0] layer_w;
  logic [4:0] layer_r;
  logic [3:0] cnta;
  logic [3:0] cntb;
  logic [8:0] w_address;
  logic [8:0] r_address;
  logic       w_en;
  logic       r_en;
  logic       rdata_valid;
  logic       rdata_last;
  logic       err;

  modport master (
    output wr_valid, wr_layer, wr_node, rd_valid, rd_layer, rd_node,
    input  wr_ready, rd_ready, layer_w, layer_r, cnta, cntb, w_address, r_address,
    input  w_en, r_en, rdata_valid, rdata_last, err
  );

  modport slave (
    input  wr_valid, wr_layer, wr_node, rd_valid, rd_layer, rd_node,
    output wr_ready, rd_ready, layer_w, layer_r, cnta, cntb, w_address, r_address,
    output w_en, r_en, rdata_valid, rdata_last, err
  );
endinterface

// File: rtl/b_ram_sched.sv
// b_ram_sched: splits b-RAM write/read requests into per-beat layer/counter/address/enable.
// Latency: first beat one cycle after acceptance, then one beat per cycle.
// Backpressure: wr_ready/rd_ready low while a burst runs (read also on a RAW hazard).
// Ports: clk/rst (async, active-high) plus bus (b_ram_sched_if.slave) carrying both
// request handshakes and all RAM-facing outputs. Optional macro B_RAM_RAW_CHECK_EN
// enables the read-after-write interlock; without it rd_ready depends only on the read FSM.
module b_ram_sched #(
  parameter int P    = 128,
  parameter int Q    = 6,
  parameter int LOGN = 10
) (
  input  logic         clk,
  input  logic         rst,
  b_ram_sched_if.slave bus
);

  // A read beat carries P lanes, a write beat 2P; layer L holds 2^L values.
  localparam int RD_TH = $clog2(P);
  localparam int WR_TH = RD_TH + 1;

  if (P < 2 || Q < 1) begin : g_bad_cfg
    $error("b_ram_sched: unsupported P/Q");
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  function automatic logic legal(input logic [4:0] l, input logic [8:0] n);
    if (l == 5'd0 || int'(l) > LOGN) return 1'b0;
    return (32'(n) >> (LOGN - int'(l))) == 32'd0;
  endfunction

  function automatic logic [3:0] last_beat(input logic [4:0] l, input int th);
    if (int'(l) <= th) return 4'd0;
    return 4'((32'd1 << (int'(l) - th)) - 32'd1);
  endfunction

  // Multi-beat layers start at node 0; the beat counter selects the slice.
  function automatic logic [8:0] beat_addr(input logic [4:0] l, input logic [8:0] n);
    return (int'(l) <= RD_TH) ? n : 9'd0;
  endfunction

`ifdef B_RAM_RAW_CHECK_EN
  function automatic logic conflict(input logic [4:0] la, input logic [8:0] na,
                                    input logic [4:0] lb, input logic [8:0] nb);
    return (la == lb && na == nb) || (int'(la) > RD_TH && int'(lb) > RD_TH);
  endfunction
`endif

  state_e     wr_state_q, wr_state_d, rd_state_q, rd_state_d;
  logic [4:0] layer_w_q, layer_w_d, layer_r_q, layer_r_d;
  logic [3:0] cnta_q, cnta_d, cntb_q, cntb_d;
  logic [3:0] w_last_q, w_last_d, r_last_q, r_last_d;
  logic [8:0] w_addr_q, w_addr_d, r_addr_q, r_addr_d;
  logic       rdv_q, rdl_q, err_q, err_d;
  logic       wr_rdy, rd_rdy, w_en, r_en, rd_stall;
  logic       wr_legal, rd_legal, wr_take, rd_take;
`ifdef B_RAM_RAW_CHECK_EN
  logic [8:0] w_node_q, w_node_d;
  logic       hold_q, hold_d;    // read accepted together with a conflicting write
  logic [4:0] pl_q, pl_d;
  logic [8:0] pn_q, pn_d;
`endif

  // ---------------- output / handshake logic ----------------
  always_comb begin
    wr_rdy = (wr_state_q == IDLE);
    w_en   = (wr_state_q == RUN);
`ifdef B_RAM_RAW_CHECK_EN
    rd_stall = w_en && conflict(bus.rd_layer, bus.rd_node, layer_w_q, w_node_q);
    r_en     = (rd_state_q == RUN) && !hold_q;
`else
    rd_stall = 1'b0;
    r_en     = (rd_state_q == RUN);
`endif
    rd_rdy   = (rd_state_q == IDLE) && !rd_stall;
    wr_legal = legal(bus.wr_layer, bus.wr_node);
    rd_legal = legal(bus.rd_layer, bus.rd_node);
    wr_take  = bus.wr_valid && wr_rdy && wr_legal;
    rd_take  = bus.rd_valid && rd_rdy && rd_legal;
    err_d    = (bus.wr_valid && wr_rdy && !wr_legal) || (bus.rd_valid && rd_rdy && !rd_legal);
  end

  // ---------------- write FSM next state ----------------
  always_comb begin
    wr_state_d = wr_state_q;
    layer_w_d  = layer_w_q;
    cnta_d     = cnta_q;
    w_last_d   = w_last_q;
    w_addr_d   = w_addr_q;
`ifdef B_RAM_RAW_CHECK_EN
    w_node_d   = w_node_q;
`endif
    unique case (wr_state_q)
      IDLE: begin
        if (wr_take) begin
          wr_state_d = RUN;
          layer_w_d  = bus.wr_layer;
          cnta_d     = 4'd0;
          w_last_d   = last_beat(bus.wr_layer, WR_TH);
          w_addr_d   = beat_addr(bus.wr_layer, bus.wr_node);
`ifdef B_RAM_RAW_CHECK_EN
          w_node_d   = bus.wr_node;
`endif
        end
      end
      RUN: begin
        if (cnta_q == w_last_q) wr_state_d = IDLE;
        else                    cnta_d     = cnta_q + 4'd1;
      end
    endcase
  end

  // ---------------- read FSM next state ----------------
  always_comb begin
    rd_state_d = rd_state_q;
    layer_r_d  = layer_r_q;
    cntb_d     = cntb_q;
    r_last_d   = r_last_q;
    r_addr_d   = r_addr_q;
`ifdef B_RAM_RAW_CHECK_EN
    hold_d     = hold_q;
    pl_d       = pl_q;
    pn_d       = pn_q;
`endif
    unique case (rd_state_q)
      IDLE: begin
        if (rd_take) begin
          rd_state_d = RUN;
`ifdef B_RAM_RAW_CHECK_EN
          // RAM outputs must keep their old values while parked, so park the request aside.
          if (wr_take && conflict(bus.rd_layer, bus.rd_node, bus.wr_layer, bus.wr_node)) begin
            hold_d = 1'b1;
            pl_d   = bus.rd_layer;
            pn_d   = bus.rd_node;
          end else begin
`else
          begin
`endif
            layer_r_d = bus.rd_layer;
            cntb_d    = 4'd0;
            r_last_d  = last_beat(bus.rd_layer, RD_TH);
            r_addr_d  = beat_addr(bus.rd_layer, bus.rd_node);
          end
        end
      end
      RUN: begin
`ifdef B_RAM_RAW_CHECK_EN
        if (hold_q) begin
          // Release on the write's last beat so the first read beat follows it directly.
          if (!w_en || cnta_q == w_last_q) begin
            hold_d    = 1'b0;
            layer_r_d = pl_q;
            cntb_d    = 4'd0;
            r_last_d  = last_beat(pl_q, RD_TH);
            r_addr_d  = beat_addr(pl_q, pn_q);
          end
        end else
`endif
        if (cntb_q == r_last_q) rd_state_d = IDLE;
        else                    cntb_d     = cntb_q + 4'd1;
      end
    endcase
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= IDLE;
      rd_state_q <= IDLE;
      layer_w_q  <= '0;
      layer_r_q  <= '0;
      cnta_q     <= '0;
      cntb_q     <= '0;
      w_last_q   <= '0;
      r_last_q   <= '0;
      w_addr_q   <= '0;
      r_addr_q   <= '0;
      rdv_q      <= 1'b0;
      rdl_q      <= 1'b0;
      err_q      <= 1'b0;
`ifdef B_RAM_RAW_CHECK_EN
      w_node_q   <= '0;
      hold_q     <= 1'b0;
      pl_q       <= '0;
      pn_q       <= '0;
`endif
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      layer_w_q  <= layer_w_d;
      layer_r_q  <= layer_r_d;
      cnta_q     <= cnta_d;
      cntb_q     <= cntb_d;
      w_last_q   <= w_last_d;
      r_last_q   <= r_last_d;
      w_addr_q   <= w_addr_d;
      r_addr_q   <= r_addr_d;
      // RAM output register lags r_en by one cycle
      rdv_q      <= r_en;
      rdl_q      <= r_en && (cntb_q == r_last_q);
      err_q      <= err_d;
`ifdef B_RAM_RAW_CHECK_EN
      w_node_q   <= w_node_d;
      hold_q     <= hold_d;
      pl_q       <= pl_d;
      pn_q       <= pn_d;
`endif
    end
  end

  assign bus.wr_ready    = wr_rdy;
  assign bus.rd_ready    = rd_rdy;
  assign bus.layer_w     = layer_w_q;
  assign bus.layer_r     = layer_r_q;
  assign bus.cnta        = cnta_q;
  assign bus.cntb        = cntb_q;
  assign bus.w_address   = w_addr_q;
  assign bus.r_address   = r_addr_q;
  assign bus.w_en        = w_en;
  assign bus.r_en        = r_en;
  assign bus.rdata_valid = rdv_q;
  assign bus.rdata_last  = rdl_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_b_ram_sched.sv
// Bench for b_ram_sched: cycle-indexed transaction model (burst start/end cycles,
// held output values) compared against the DUT every cycle, plus directed scenarios
// with hand-computed literal expectations.
module tb_b_ram_sched;
  localparam int LOGN = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  b_ram_sched_if bus ();

  b_ram_sched #(.P(128), .Q(6), .LOGN(LOGN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model state: bursts are described by the cycle numbers they occupy
  int cyc;
  int w_start, w_end, r_start, r_end;
  int w_layer, w_node, w_addr, r_layer, r_addr;
  int e_lw, e_cnta, e_wa, e_lr, e_cntb, e_ra;
  bit prev_ren, prev_rlast, err_next;
  bit last_wacc, last_racc;
  // current stimulus
  bit wv, rv;
  int wl, wn, rl, rn;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_legal(input int l, input int n);
    if (l < 1 || l > LOGN) return 1'b0;
    return n < (1 << (LOGN - l));
  endfunction

  function automatic int beats_w(input int l);
    return (l <= 8) ? 1 : (1 << (l - 8));
  endfunction

  function automatic int beats_r(input int l);
    return (l <= 7) ? 1 : (1 << (l - 7));
  endfunction

  function automatic int addr_of(input int l, input int n);
    return (l <= 7) ? n : 0;
  endfunction

  function automatic bit conflict(input int la, input int na, input int lb, input int nb);
    return (la == lb && na == nb) || (la > 7 && lb > 7);
  endfunction

  task automatic model_reset();
    w_start = 0; w_end = -1; r_start = 0; r_end = -1;
    w_layer = 0; w_node = 0; w_addr = 0; r_layer = 0; r_addr = 0;
    e_lw = 0; e_cnta = 0; e_wa = 0; e_lr = 0; e_cntb = 0; e_ra = 0;
    prev_ren = 0; prev_rlast = 0; err_next = 0;
    last_wacc = 0; last_racc = 0;
  endtask

  // Compare all outputs of the current cycle, then apply this cycle's handshakes.
  task automatic eval_cycle();
    int c;
    bit w_run, r_run, stall, e_wrdy, e_rrdy, hold;
    c = cyc;
    w_run = (c >= w_start) && (c <= w_end);
    r_run = (c >= r_start) && (c <= r_end);
    if (w_run) begin e_lw = w_layer; e_cnta = c - w_start; e_wa = w_addr; end
    if (r_run) begin e_lr = r_layer; e_cntb = c - r_start; e_ra = r_addr; end
    stall = 1'b0;
`ifdef B_RAM_RAW_CHECK_EN
    stall = w_run && conflict(rl, rn, w_layer, w_node);
`endif
    e_wrdy = (c > w_end);
    e_rrdy = (c > r_end) && !stall;

    chk("wr_ready",    bus.wr_ready,    int'(e_wrdy));
    chk("rd_ready",    bus.rd_ready,    int'(e_rrdy));
    chk("w_en",        bus.w_en,        int'(w_run));
    chk("r_en",        bus.r_en,        int'(r_run));
    chk("layer_w",     bus.layer_w,     e_lw);
    chk("cnta",        bus.cnta,        e_cnta);
    chk("w_address",   bus.w_address,   e_wa);
    chk("layer_r",     bus.layer_r,     e_lr);
    chk("cntb",        bus.cntb,        e_cntb);
    chk("r_address",   bus.r_address,   e_ra);
    chk("rdata_valid", bus.rdata_valid, int'(prev_ren));
    chk("rdata_last",  bus.rdata_last,  int'(prev_rlast));
    chk("err",         bus.err,         int'(err_next));

    prev_ren   = r_run;
    prev_rlast = r_run && (c == r_end);
    err_next   = 1'b0;
    last_wacc  = wv && e_wrdy;
    last_racc  = rv && e_rrdy;
    hold       = 1'b0;
    if (last_wacc) begin
      if (is_legal(wl, wn)) begin
        w_start = c + 1;
        w_end   = c + beats_w(wl);
        w_layer = wl; w_node = wn; w_addr = addr_of(wl, wn);
      end else err_next = 1'b1;
    end
    if (last_racc) begin
      if (is_legal(rl, rn)) begin
`ifdef B_RAM_RAW_CHECK_EN
        hold = last_wacc && is_legal(wl, wn) && conflict(rl, rn, wl, wn);
`endif
        r_start = hold ? (w_end + 1) : (c + 1);
        r_end   = r_start + beats_r(rl) - 1;
        r_layer = rl; r_addr = addr_of(rl, rn);
      end else err_next = 1'b1;
    end
  endtask

  task automatic step(input bit a_wv, input int a_wl, input int a_wn,
                      input bit a_rv, input int a_rl, input int a_rn);
    @(posedge clk);
    #1;
    wv = a_wv; wl = a_wl; wn = a_wn; rv = a_rv; rl = a_rl; rn = a_rn;
    bus.wr_valid = a_wv; bus.wr_layer = 5'(a_wl); bus.wr_node = 9'(a_wn);
    bus.rd_valid = a_rv; bus.rd_layer = 5'(a_rl); bus.rd_node = 9'(a_rn);
    cyc++;
    @(negedge clk);
    eval_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".wr_ready"}, bus.wr_ready, 1);
    chk({tag, ".rd_ready"}, bus.rd_ready, 1);
    chk({tag, ".w_en"}, bus.w_en, 0);
    chk({tag, ".r_en"}, bus.r_en, 0);
    chk({tag, ".layer_w"}, bus.layer_w, 0);
    chk({tag, ".layer_r"}, bus.layer_r, 0);
    chk({tag, ".cnta"}, bus.cnta, 0);
    chk({tag, ".cntb"}, bus.cntb, 0);
    chk({tag, ".w_address"}, bus.w_address, 0);
    chk({tag, ".r_address"}, bus.r_address, 0);
    chk({tag, ".rdata_valid"}, bus.rdata_valid, 0);
    chk({tag, ".rdata_last"}, bus.rdata_last, 0);
    chk({tag, ".err"}, bus.err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int il_l[3];
    int il_n[3];
    int ren_cnt, rdv_cnt, last_pos, waits, l, n, lim;

    il_l = '{0, 11, 4};
    il_n = '{0, 0, 64};
    bus.wr_valid = 0; bus.wr_layer = 0; bus.wr_node = 0;
    bus.rd_valid = 0; bus.rd_layer = 0; bus.rd_node = 0;
    wv = 0; rv = 0; wl = 0; wn = 0; rl = 0; rn = 0;
    cyc = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_values("reset");

    // write layer 3 node 5: one beat, one cycle after acceptance
    step(1, 3, 5, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("wr3.w_en", bus.w_en, 1);
    chk("wr3.layer_w", bus.layer_w, 3);
    chk("wr3.w_address", bus.w_address, 5);
    chk("wr3.cnta", bus.cnta, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("wr3.w_en_off", bus.w_en, 0);
    chk("wr3.wr_ready", bus.wr_ready, 1);

    // read layer 10 node 0: 8 beats, rdata_last on the 8th valid cycle
    step(0, 0, 0, 1, 10, 0);
    ren_cnt = 0; rdv_cnt = 0; last_pos = 0;
    for (int i = 0; i < 11; i++) begin
      step(0, 0, 0, 0, 0, 0);
      if (bus.r_en === 1'b1) begin
        chk("rd10.cntb", bus.cntb, ren_cnt);
        chk("rd10.r_address", bus.r_address, 0);
        ren_cnt++;
      end
      if (bus.rdata_valid === 1'b1) rdv_cnt++;
      if (bus.rdata_last === 1'b1) last_pos = rdv_cnt;
    end
    chk("rd10.beats", ren_cnt, 8);
    chk("rd10.valid_beats", rdv_cnt, 8);
    chk("rd10.last_pos", last_pos, 8);

    // write layer 9 then read layer 9 the next cycle
    step(1, 9, 0, 0, 0, 0);
    waits = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, 1, 9, 0);
      if (last_racc) break;
      waits++;
    end
`ifdef B_RAM_RAW_CHECK_EN
    chk("raw.wait_cycles", waits, 2);
`else
    chk("raw.wait_cycles", waits, 0);
`endif
    idle(12);

    // illegal requests on both ports
    for (int i = 0; i < 6; i++) begin
      if (i < 3) step(1, il_l[i], il_n[i], 0, 0, 0);
      else       step(0, 0, 0, 1, il_l[i-3], il_n[i-3]);
      step(0, 0, 0, 0, 0, 0);
      chk("illegal.err", bus.err, 1);
      chk("illegal.w_en", bus.w_en, 0);
      chk("illegal.r_en", bus.r_en, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("illegal.err_off", bus.err, 0);
      chk("illegal.ready", (i < 3) ? bus.wr_ready : bus.rd_ready, 1);
    end

    // concurrent write L2/N1 and read L5/N3
    step(1, 2, 1, 1, 5, 3);
    step(0, 0, 0, 0, 0, 0);
    chk("conc.w_en", bus.w_en, 1);
    chk("conc.r_en", bus.r_en, 1);
    chk("conc.w_address", bus.w_address, 1);
    chk("conc.r_address", bus.r_address, 3);
    chk("conc.err", bus.err, 0);
    idle(2);

    // randomized traffic, biased toward conflicts and boundary nodes
    for (int i = 0; i < 3000; i++) begin
      bit a_wv, a_rv;
      int a_wl, a_wn, a_rl, a_rn;
      a_wv = ($urandom_range(0, 2) == 0);
      a_rv = ($urandom_range(0, 2) == 0);
      for (int s = 0; s < 2; s++) begin
        l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) : int'($urandom_range(6, 10));
        if (l >= 1 && l <= LOGN) begin
          lim = 1 << (LOGN - l);
          if (lim > 511) lim = 511;
          n = ($urandom_range(0, 7) == 0) ? lim : int'($urandom_range(0, lim - ((lim == 511) ? 0 : 1)));
        end else n = $urandom_range(0, 511);
        if (s == 0) begin a_wl = l; a_wn = n; end
        else        begin a_rl = l; a_rn = n; end
      end
      if ($urandom_range(0, 3) == 0) begin a_rl = a_wl; a_rn = a_wn; end
      step(a_wv, a_wl, a_wn, a_rv, a_rl, a_rn);
    end
    idle(20);

    // reset in the 3rd beat of a layer-9 read
    step(0, 0, 0, 1, 9, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("rst.r_en_before", bus.r_en, 1);
    rst = 1'b1;
    #1;
    chk("rst.r_en", bus.r_en, 0);
    chk("rst.rdata_valid", bus.rdata_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk_reset_values("post_rst");
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
